// File: rtl/bsg_gray_ptr_pkg.sv
// Shared helpers for the gray pointer receive synchronizer:
// the warm-up counter sizing rule and a Hamming-distance function.
package bsg_gray_ptr_pkg;

  // Widest pointer the Hamming-distance helper accepts.
  localparam int unsigned hd_max_width_lp = 256;

  // The warm-up counter must hold S+1, so it needs clog2(S+2) bits.
  function automatic int unsigned warmup_width(input int unsigned stages);
    return $clog2(stages + 32'd2);
  endfunction

  function automatic logic [8:0] hamming_dist(input logic [hd_max_width_lp-1:0] a,
                                              input logic [hd_max_width_lp-1:0] b);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < hd_max_width_lp; i++) begin
      cnt = cnt + {8'd0, a[i] ^ b[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Combinational gray-to-binary conversion: each binary bit is the XOR of
// all gray bits at or above it.
module bsg_gray_to_binary #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  for (genvar i = 0; i < width_p; i++) begin : g_bit
    assign binary_o[i] = ^gray_i[width_p-1:i];
  end

endmodule

// File: rtl/bsg_sync_chain.sv
// Plain multi-flop synchronizer; kept as its own module so CDC constraints
// can target its instances. Only stage 0 samples the foreign data.
module bsg_sync_chain #(
  parameter int width_p       = 32,
  parameter int sync_stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] sync_r [sync_stages_p];

  // Shift the asynchronous input through the chain with no logic in between.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < sync_stages_p; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= d_i;
      for (int k = 1; k < sync_stages_p; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign q_o = sync_r[sync_stages_p-1];

endmodule

// File: rtl/bsg_gray_ptr_sync_rx.sv
// Receive-side gray pointer synchronizer: syncs a foreign gray pointer,
// converts it to binary, reports per-cycle advance and optional step errors.
module bsg_gray_ptr_sync_rx
  import bsg_gray_ptr_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int sync_stages_p = 2,
  parameter int check_p       = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] ptr_gray_i,
  input  logic               err_clear_i,
  output logic [width_p-1:0] ptr_gray_o,
  output logic [width_p-1:0] ptr_binary_o,
  output logic [width_p-1:0] delta_o,
  output logic               delta_v_o,
  output logic               ready_o,
  output logic               err_o
);

  localparam int unsigned wu_w_lp = warmup_width(sync_stages_p);
  localparam logic [wu_w_lp-1:0] wu_max_lp = wu_w_lp'(sync_stages_p + 32'd1);

  logic [width_p-1:0] sync_last_s;
  logic [width_p-1:0] b_n_s;
  logic [width_p-1:0] delta_next_s;
  logic [wu_w_lp-1:0] wu_next_s;
  logic [8:0]         hd_s;
  logic               err_set_s;

  logic [width_p-1:0] bin_r;
  logic [width_p-1:0] delta_r;
  logic [width_p-1:0] gray_prev_r;
  logic [wu_w_lp-1:0] wu_r;
  logic               ready_r;
  logic               delta_v_r;
  logic               err_r;

  bsg_sync_chain #(
    .width_p      (width_p),
    .sync_stages_p(sync_stages_p)
  ) sync_chain (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (ptr_gray_i),
    .q_o    (sync_last_s)
  );

  bsg_gray_to_binary #(
    .width_p(width_p)
  ) g2b (
    .gray_i  (sync_last_s),
    .binary_o(b_n_s)
  );

  // Next-state for warm-up, delta and the gray step check.
  always_comb begin
    wu_next_s    = wu_r;
    delta_next_s = '0;
    hd_s         = hamming_dist(hd_max_width_lp'(sync_last_s),
                                hd_max_width_lp'(gray_prev_r));
    err_set_s    = 1'b0;
    if (wu_r != wu_max_lp) begin
      wu_next_s = wu_r + wu_w_lp'(1'b1);
    end else begin
      wu_next_s = wu_r;
    end
    // Until warmed up the delta stays 0, so the first post-reset pointer is absorbed.
    if (ready_r) begin
      delta_next_s = b_n_s - bin_r;
    end else begin
      delta_next_s = '0;
    end
    if ((check_p != 0) && ready_r && (hd_s > 9'd1)) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Binary pointer, delta, warm-up and sticky error registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bin_r       <= '0;
      delta_r     <= '0;
      gray_prev_r <= '0;
      wu_r        <= '0;
      ready_r     <= 1'b0;
      delta_v_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      bin_r       <= b_n_s;
      delta_r     <= delta_next_s;
      gray_prev_r <= sync_last_s;
      wu_r        <= wu_next_s;
      ready_r     <= (wu_next_s == wu_max_lp);
      delta_v_r   <= (wu_next_s == wu_max_lp) && (delta_next_s != '0);
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clear_i) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign ptr_gray_o   = sync_last_s;
  assign ptr_binary_o = bin_r;
  assign delta_o      = delta_r;
  assign delta_v_o    = delta_v_r;
  assign ready_o      = ready_r;
  assign err_o        = (check_p != 0) ? err_r : 1'b0;

endmodule
